// File: rtl/result_drain_pkg.sv
// Shared constants and drain FSM state encoding for result_drain.
// RESULT_DRAIN_CHECKSUM_EN adds the CKSUM state for the trailing checksum beat.
package result_drain_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

`ifdef RESULT_DRAIN_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CKSUM = 2'd2
  } state_e;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;
`endif

endpackage

// File: rtl/result_drain_if.sv
// Write port from the transfer block plus the valid/ready result stream.
// master = result_drain side, slave = transfer block / consumer side.
interface result_drain_if;
  import result_drain_pkg::*;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic [AW-1:0] dout_idx;
  logic [7:0]    frame_cnt;
  logic          overflow;

  modport master (
    input  wr_en, wr_addr, wr_data, dout_ready,
    output dout, dout_valid, dout_last, dout_idx, frame_cnt, overflow
  );

  modport slave (
    output wr_en, wr_addr, wr_data, dout_ready,
    input  dout, dout_valid, dout_last, dout_idx, frame_cnt, overflow
  );

endinterface

// File: rtl/result_bank.sv
// One DEPTH x DW frame bank with a per-address written mask.
// all_written pulses on the write that completes the mask; the mask self-clears then.
module result_bank
  import result_drain_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          all_written
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] mask_q, mask_d, mask_set;

  always_comb begin
    mem_d       = mem_q;
    mask_d      = mask_q;
    mask_set    = mask_q;
    all_written = 1'b0;
    if (we) begin
      mem_d[wr_addr]    = wr_data;
      mask_set[wr_addr] = 1'b1;
      mask_d            = mask_set;
      if (&mask_set) begin
        all_written = 1'b1;
        mask_d      = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  // Data is never read before its mask fills, so it needs no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/result_drain.sv
// Ping-pong capture of transfer-block results and in-order frame streaming.
// Optional RESULT_DRAIN_CHECKSUM_EN appends a mod-256 sum beat to each frame.
module result_drain
  import result_drain_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  result_drain_if.master bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fill_sel_q, fill_sel_d;
  logic          drain_sel_q, drain_sel_d;
  logic [1:0]    full_q, full_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          overflow_q, overflow_d;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [DW-1:0] cksum_q, cksum_d;
`endif

  logic          wr_ok;
  logic [1:0]    bank_we;
  logic [DW-1:0] rd_data [2];
  logic [1:0]    all_written;
  logic          fill_done;
  logic          release_bank;
  logic          valid_w, last_w;
  logic [DW-1:0] dout_w;
  logic [AW-1:0] idx_w;

  // Admission uses the registered full flag only; a same-cycle release does not count.
  assign wr_ok      = bus.wr_en && !full_q[fill_sel_q];
  assign bank_we[0] = wr_ok && !fill_sel_q;
  assign bank_we[1] = wr_ok &&  fill_sel_q;
  assign fill_done  = |all_written;

  result_bank u_bank0 (
    .clock       (clock),
    .reset       (reset),
    .we          (bank_we[0]),
    .wr_addr     (bus.wr_addr),
    .wr_data     (bus.wr_data),
    .rd_addr     (rd_ptr_q),
    .rd_data     (rd_data[0]),
    .all_written (all_written[0])
  );

  result_bank u_bank1 (
    .clock       (clock),
    .reset       (reset),
    .we          (bank_we[1]),
    .wr_addr     (bus.wr_addr),
    .wr_data     (bus.wr_data),
    .rd_addr     (rd_ptr_q),
    .rd_data     (rd_data[1]),
    .all_written (all_written[1])
  );

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    drain_sel_d  = drain_sel_q;
    frame_cnt_d  = frame_cnt_q;
    release_bank = 1'b0;
    valid_w      = 1'b0;
    last_w       = 1'b0;
    dout_w       = '0;
    idx_w        = '0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
    cksum_d      = cksum_q;
`endif

    case (state_q)
      IDLE: begin
        if (full_q[drain_sel_q]) begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
          cksum_d  = '0;
`endif
        end
      end
      DRAIN: begin
        valid_w = 1'b1;
        dout_w  = rd_data[drain_sel_q];
        idx_w   = rd_ptr_q;
`ifndef RESULT_DRAIN_CHECKSUM_EN
        last_w  = (rd_ptr_q == LAST_IDX);
`endif
        if (bus.dout_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
`ifdef RESULT_DRAIN_CHECKSUM_EN
          cksum_d  = cksum_q + dout_w;
          if (rd_ptr_q == LAST_IDX) state_d = CKSUM;
`else
          if (rd_ptr_q == LAST_IDX) release_bank = 1'b1;
`endif
        end
      end
`ifdef RESULT_DRAIN_CHECKSUM_EN
      CKSUM: begin
        valid_w = 1'b1;
        dout_w  = cksum_q;
        last_w  = 1'b1;
        if (bus.dout_ready) release_bank = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Chain straight into the other bank when it is already full: no idle beat.
    if (release_bank) begin
      drain_sel_d = ~drain_sel_q;
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (full_q[~drain_sel_q]) begin
        state_d  = DRAIN;
        rd_ptr_d = '0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
        cksum_d  = '0;
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Fill completion and drain release always target different banks.
  always_comb begin
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    overflow_d = overflow_q | (bus.wr_en & full_q[fill_sel_q]);
    if (release_bank) full_d[drain_sel_q] = 1'b0;
    if (fill_done) begin
      full_d[fill_sel_q] = 1'b1;
      fill_sel_d         = ~fill_sel_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      full_q      <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      full_q      <= full_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
`ifdef RESULT_DRAIN_CHECKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  assign bus.dout       = dout_w;
  assign bus.dout_valid = valid_w;
  assign bus.dout_last  = last_w;
  assign bus.dout_idx   = idx_w;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: directed frames push expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_result_drain;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
  } beat_t;

`ifdef RESULT_DRAIN_CHECKSUM_EN
  localparam int unsigned BEATS = 5;
`else
  localparam int unsigned BEATS = 4;
`endif

  logic clock;
  logic reset;
  result_drain_if bus ();

  result_drain dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  beat_t       sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] sum;
    sum = d0 + d1 + d2 + d3;
`ifdef RESULT_DRAIN_CHECKSUM_EN
    sb.push_back('{d0, 2'd0, 1'b0});
    sb.push_back('{d1, 2'd1, 1'b0});
    sb.push_back('{d2, 2'd2, 1'b0});
    sb.push_back('{d3, 2'd3, 1'b0});
    sb.push_back('{sum, 2'd0, 1'b1});
`else
    sb.push_back('{d0, 2'd0, 1'b0});
    sb.push_back('{d1, 2'd1, 1'b0});
    sb.push_back('{d2, 2'd2, 1'b0});
    sb.push_back('{d3, 2'd3, 1'b1});
    if (sum === 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clock); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    wr(2'd0, d0); wr(2'd1, d1); wr(2'd2, d2); wr(2'd3, d3);
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || bus.dout_valid) && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    chk(name, 32'(n < 60), 32'd1);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && bus.dout_valid && bus.dout_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(bus.dout), 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_data", 32'(bus.dout), 32'(e.data));
        chk("beat_idx", 32'(bus.dout_idx), 32'(e.idx));
        chk("beat_last", 32'(bus.dout_last), 32'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.dout_ready = 1'b0;
    reset          = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_last", 32'(bus.dout_last), 32'd0);
    chk("rst_idx", 32'(bus.dout_idx), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    @(posedge clock); #1;

    // Basic frame, ready high; first beat one cycle after the completing write
    bus.dout_ready = 1'b1;
    push_frame(8'h10, 8'h20, 8'h30, 8'h40);
    wr_frame(8'h10, 8'h20, 8'h30, 8'h40);
    @(negedge clock);
    chk("latency_pre_valid", 32'(bus.dout_valid), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("latency_valid", 32'(bus.dout_valid), 32'd1);
    chk("latency_dout", 32'(bus.dout), 32'h10);
    @(posedge clock); #1;
    wait_drain("drain1_done");
    chk("frame_cnt_1", 32'(bus.frame_cnt), 32'd1);

    // Backpressure on beat 1 for 3 cycles
    bus.dout_ready = 1'b0;
    push_frame(8'h10, 8'h20, 8'h30, 8'h40);
    wr_frame(8'h10, 8'h20, 8'h30, 8'h40);
    for (int i = 0; i < 10 && !bus.dout_valid; i++) begin
      @(posedge clock); #1;
    end
    chk("stall_first_valid", 32'(bus.dout_valid), 32'd1);
    bus.dout_ready = 1'b1;
    @(posedge clock); #1;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_valid", 32'(bus.dout_valid), 32'd1);
      chk("stall_dout", 32'(bus.dout), 32'h20);
      chk("stall_idx", 32'(bus.dout_idx), 32'd1);
    end
    @(posedge clock); #1;
    bus.dout_ready = 1'b1;
    wait_drain("drain2_done");
    chk("frame_cnt_2", 32'(bus.frame_cnt), 32'd2);

    // Out-of-order writes with a rewrite; full only after addr 2
    push_frame(8'hA0, 8'h55, 8'hA2, 8'hA3);
    wr(2'd3, 8'hA3); wr(2'd1, 8'hA1); wr(2'd0, 8'hA0); wr(2'd1, 8'h55);
    @(negedge clock);
    chk("not_full_early_a", 32'(bus.dout_valid), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("not_full_early_b", 32'(bus.dout_valid), 32'd0);
    @(posedge clock); #1;
    wr(2'd2, 8'hA2);
    wait_drain("drain3_done");
    chk("frame_cnt_3", 32'(bus.frame_cnt), 32'd3);
    chk("no_overflow_yet", 32'(bus.overflow), 32'd0);

    // Two frames under backpressure, 9th write dropped, then back-to-back drain
    bus.dout_ready = 1'b0;
    push_frame(8'h01, 8'h02, 8'h03, 8'h04);
    push_frame(8'h05, 8'h06, 8'h07, 8'h08);
    wr_frame(8'h01, 8'h02, 8'h03, 8'h04);
    wr_frame(8'h05, 8'h06, 8'h07, 8'h08);
    chk("overflow_clear_8", 32'(bus.overflow), 32'd0);
    wr(2'd0, 8'hFF);
    chk("overflow_set", 32'(bus.overflow), 32'd1);
    bus.dout_ready = 1'b1;
    for (int i = 0; i < int'(2 * BEATS); i++) begin
      @(negedge clock);
      chk("no_bubble_valid", 32'(bus.dout_valid), 32'd1);
    end
    @(posedge clock); #1;
    @(negedge clock);
    chk("dropped_not_drained", 32'(bus.dout_valid), 32'd0);
    chk("frame_cnt_5", 32'(bus.frame_cnt), 32'd5);
    chk("overflow_sticky", 32'(bus.overflow), 32'd1);
    chk("sb_empty_4", 32'(sb.size()), 32'd0);
    @(posedge clock); #1;

    // Reset in the middle of a drain (during beat 2)
    sb.push_back('{8'h21, 2'd0, 1'b0});
    sb.push_back('{8'h22, 2'd1, 1'b0});
    wr_frame(8'h21, 8'h22, 8'h23, 8'h24);
    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("pre_reset_idx", 32'(bus.dout_idx), 32'd2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("mid_rst_dout", 32'(bus.dout), 32'd0);
    chk("mid_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    chk("mid_rst_sb", 32'(sb.size()), 32'd0);
    @(posedge clock); #1;
    push_frame(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    wr_frame(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    wait_drain("drain_post_rst");
    chk("frame_cnt_post_rst", 32'(bus.frame_cnt), 32'd1);

    // Checksum frame: sum 0x80+0x90+0x01+0x02 = 0x113 -> 0x13
    push_frame(8'h80, 8'h90, 8'h01, 8'h02);
    wr_frame(8'h80, 8'h90, 8'h01, 8'h02);
    wait_drain("drain_cksum_frame");
    chk("frame_cnt_final", 32'(bus.frame_cnt), 32'd2);
    chk("sb_empty_final", 32'(sb.size()), 32'd0);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
